// File: rtl/core_pkg.sv
// Shared core definitions: data width, register count, scoreboard depth.
// Used by the register file / in-flight scoreboard and its counters.
package core_pkg;

    localparam int XLEN         = 64;
    localparam int NUM_REGS     = 32;
    localparam int REG_IDX_W    = 5;
    localparam int MAX_INFLIGHT = 4;
    localparam int CW           = $clog2(MAX_INFLIGHT + 1);

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xlen_t;

    // x0 is hard-wired to zero and never tracked or written
    function automatic logic is_arch_reg(input reg_idx_t idx);
        return idx != '0;
    endfunction

endpackage

// File: rtl/inflight_counter.sv
// Saturating up/down counter of outstanding writes to one register.
// A clear (fetch redirect) beats any increment or decrement in the same cycle.
module inflight_counter
    import core_pkg::*;
(
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          clr,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          full
);

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

    // Count reservations up and retirements down; never wraps in either direction
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end else if (dec && !inc) begin
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign full = (cnt == CNT_MAX);

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with a per-register in-flight write scoreboard.
// Writeback writes results and retires reservations; decode reads two sources,
// reserves its destination on issue and is stalled while a source is pending.
// Optional feature: define REGFILE_WB_BYPASS_EN to forward the writeback
// result to same-cycle reads and to treat a source whose last pending write
// retires this cycle as ready.
module regfile_scoreboard
    import core_pkg::*;
(
    input  logic     CLK,
    input  logic     RESET_N,
    input  logic     WB_REG_WEN,
    input  reg_idx_t WB_DR,
    input  xlen_t    WB_DATA,
    input  logic     WB_FLUSH,
    input  logic     DE_V,
    input  reg_idx_t DE_SR1,
    input  reg_idx_t DE_SR2,
    input  reg_idx_t DE_DR,
    input  logic     DE_DR_WEN,
    output xlen_t    DE_SR1_DATA,
    output xlen_t    DE_SR2_DATA,
    output logic     DE_STALL
);

    xlen_t         regs [NUM_REGS];
    logic [CW-1:0] cnt  [NUM_REGS];
    logic          full [NUM_REGS];
    logic          reserve_en;
    logic          busy1;
    logic          busy2;

    // A flush discards this cycle's reservation; stalled instructions reserve nothing
    assign reserve_en = DE_V && DE_DR_WEN && !DE_STALL && !WB_FLUSH;

    // x0 has no writes to track, so its slot is a constant zero
    assign cnt[0]  = '0;
    assign full[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        inflight_counter u_cnt (
            .CLK     (CLK),
            .RESET_N (RESET_N),
            .clr     (WB_FLUSH),
            .inc     (reserve_en && (DE_DR == reg_idx_t'(r))),
            .dec     (WB_REG_WEN && (WB_DR == reg_idx_t'(r))),
            .cnt     (cnt[r]),
            .full    (full[r])
        );
    end

    // Commit writeback results; the write still lands on a redirect (e.g. JAL link)
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (WB_REG_WEN && is_arch_reg(WB_DR)) begin
            regs[WB_DR] <= WB_DATA;
        end
    end

    // Zero-latency operand read, optionally forwarding the writeback result
    always_comb begin
        DE_SR1_DATA = '0;
        DE_SR2_DATA = '0;
        if (is_arch_reg(DE_SR1)) begin
            DE_SR1_DATA = regs[DE_SR1];
        end
        if (is_arch_reg(DE_SR2)) begin
            DE_SR2_DATA = regs[DE_SR2];
        end
`ifdef REGFILE_WB_BYPASS_EN
        if (WB_REG_WEN && is_arch_reg(DE_SR1) && (WB_DR == DE_SR1)) begin
            DE_SR1_DATA = WB_DATA;
        end
        if (WB_REG_WEN && is_arch_reg(DE_SR2) && (WB_DR == DE_SR2)) begin
            DE_SR2_DATA = WB_DATA;
        end
`endif
    end

    // A source is pending while writes are outstanding, unless the last one is being forwarded
    always_comb begin
        busy1 = (cnt[DE_SR1] != '0);
        busy2 = (cnt[DE_SR2] != '0);
`ifdef REGFILE_WB_BYPASS_EN
        if (WB_REG_WEN && (WB_DR == DE_SR1) && (cnt[DE_SR1] == CW'(1))) begin
            busy1 = 1'b0;
        end
        if (WB_REG_WEN && (WB_DR == DE_SR2) && (cnt[DE_SR2] == CW'(1))) begin
            busy2 = 1'b0;
        end
`endif
    end

    // Hold decode on a pending source or a destination already at its in-flight limit
    always_comb begin
        DE_STALL = DE_V && !WB_FLUSH &&
                   (busy1 || busy2 || (DE_DR_WEN && full[DE_DR]));
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard. Each scenario is a table of
// per-cycle stimulus plus expected decode outputs; expectations go into a
// scoreboard queue when a cycle is driven and are popped and compared when
// the outputs are sampled on the falling edge.
// Honours REGFILE_WB_BYPASS_EN for the forwarding-dependent expectations.
module tb_regfile_scoreboard;

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK;
    logic        RESET_N;
    logic        WB_REG_WEN;
    logic [4:0]  WB_DR;
    logic [63:0] WB_DATA;
    logic        WB_FLUSH;
    logic        DE_V;
    logic [4:0]  DE_SR1;
    logic [4:0]  DE_SR2;
    logic [4:0]  DE_DR;
    logic        DE_DR_WEN;
    logic [63:0] DE_SR1_DATA;
    logic [63:0] DE_SR2_DATA;
    logic        DE_STALL;

    typedef struct {
        string       name;
        bit          rst_n;
        bit          wen;
        logic [4:0]  wdr;
        logic [63:0] wdata;
        bit          flush;
        bit          v;
        logic [4:0]  sr1;
        logic [4:0]  sr2;
        logic [4:0]  dr;
        bit          dr_wen;
        logic        e_stall;
        bit          chk;
        logic [63:0] e_d1;
        logic [63:0] e_d2;
    } step_t;

    typedef struct {
        string       name;
        logic        stall;
        bit          chk;
        logic [63:0] d1;
        logic [63:0] d2;
    } exp_t;

    exp_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    regfile_scoreboard dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .WB_REG_WEN  (WB_REG_WEN),
        .WB_DR       (WB_DR),
        .WB_DATA     (WB_DATA),
        .WB_FLUSH    (WB_FLUSH),
        .DE_V        (DE_V),
        .DE_SR1      (DE_SR1),
        .DE_SR2      (DE_SR2),
        .DE_DR       (DE_DR),
        .DE_DR_WEN   (DE_DR_WEN),
        .DE_SR1_DATA (DE_SR1_DATA),
        .DE_SR2_DATA (DE_SR2_DATA),
        .DE_STALL    (DE_STALL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic step_t st(string name, bit rst_n, bit wen, logic [4:0] wdr, logic [63:0] wdata,
                                 bit flush, bit v, logic [4:0] sr1, logic [4:0] sr2, logic [4:0] dr, bit dr_wen,
                                 logic e_stall, bit chk, logic [63:0] e_d1, logic [63:0] e_d2);
        step_t s;
        s.name = name; s.rst_n = rst_n; s.wen = wen; s.wdr = wdr; s.wdata = wdata;
        s.flush = flush; s.v = v; s.sr1 = sr1; s.sr2 = sr2; s.dr = dr; s.dr_wen = dr_wen;
        s.e_stall = e_stall; s.chk = chk; s.e_d1 = e_d1; s.e_d2 = e_d2;
        return s;
    endfunction

    function automatic exp_t to_exp(step_t s);
        exp_t e;
        e.name = s.name; e.stall = s.e_stall; e.chk = s.chk; e.d1 = s.e_d1; e.d2 = s.e_d2;
        return e;
    endfunction

    task automatic drive(step_t s);
        RESET_N    = s.rst_n;
        WB_REG_WEN = s.wen;
        WB_DR      = s.wdr;
        WB_DATA    = s.wdata;
        WB_FLUSH   = s.flush;
        DE_V       = s.v;
        DE_SR1     = s.sr1;
        DE_SR2     = s.sr2;
        DE_DR      = s.dr;
        DE_DR_WEN  = s.dr_wen;
    endtask

    task automatic test_reset();
        step_t s [$];
        exp_t  e;
        s.push_back(st("rst",      0, 0, 0, 64'h0,    0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0));
        s.push_back(st("rst_read", 1, 0, 0, 64'h0,    0, 1, 5, 0, 0, 0, 0, 1, 64'h0, 64'h0));
        s.push_back(st("wr_x0",    1, 1, 0, 64'hDEAD, 0, 0, 0, 0, 0, 0, 0, 1, 64'h0, 64'h0));
        s.push_back(st("rd_x0",    1, 0, 0, 64'h0,    0, 1, 0, 0, 0, 0, 0, 1, 64'h0, 64'h0));
        foreach (s[i]) begin
            drive(s[i]);
            sb.push_back(to_exp(s[i]));
            @(negedge CLK);
            e = sb.pop_front();
            n_checks++;
            if (DE_STALL !== e.stall) begin
                n_fail++;
                $display("[TB] FAIL %s stall: got %b expected %b", e.name, DE_STALL, e.stall);
            end
            if (e.chk) begin
                n_checks += 2;
                if (DE_SR1_DATA !== e.d1) begin
                    n_fail++;
                    $display("[TB] FAIL %s sr1_data: got %h expected %h", e.name, DE_SR1_DATA, e.d1);
                end
                if (DE_SR2_DATA !== e.d2) begin
                    n_fail++;
                    $display("[TB] FAIL %s sr2_data: got %h expected %h", e.name, DE_SR2_DATA, e.d2);
                end
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_raw_hazard();
        step_t s [$];
        exp_t  e;
        s.push_back(st("iss3",       1, 0, 0, 64'h0,    0, 1, 0, 0, 3, 1, 0,    0, 64'h0, 64'h0));
        s.push_back(st("raw3_pend",  1, 0, 0, 64'h0,    0, 1, 3, 0, 0, 0, 1,    1, 64'h0, 64'h0));
        s.push_back(st("raw3_wb",    1, 1, 3, 64'h1234, 0, 1, 3, 0, 0, 0, !BYP, 1, BYP ? 64'h1234 : 64'h0, 64'h0));
        s.push_back(st("raw3_after", 1, 0, 0, 64'h0,    0, 1, 3, 0, 0, 0, 0,    1, 64'h1234, 64'h0));
        foreach (s[i]) begin
            drive(s[i]);
            sb.push_back(to_exp(s[i]));
            @(negedge CLK);
            e = sb.pop_front();
            n_checks++;
            if (DE_STALL !== e.stall) begin
                n_fail++;
                $display("[TB] FAIL %s stall: got %b expected %b", e.name, DE_STALL, e.stall);
            end
            if (e.chk) begin
                n_checks += 2;
                if (DE_SR1_DATA !== e.d1) begin
                    n_fail++;
                    $display("[TB] FAIL %s sr1_data: got %h expected %h", e.name, DE_SR1_DATA, e.d1);
                end
                if (DE_SR2_DATA !== e.d2) begin
                    n_fail++;
                    $display("[TB] FAIL %s sr2_data: got %h expected %h", e.name, DE_SR2_DATA, e.d2);
                end
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_saturation();
        step_t s [$];
        exp_t  e;
        for (int k = 0; k < 4; k++) begin
            s.push_back(st($sformatf("iss7_%0d", k), 1, 0, 0, 64'h0, 0, 1, 0, 0, 7, 1, 0, 0, 64'h0, 64'h0));
        end
        s.push_back(st("iss7_full",  1, 0, 0, 64'h0,  0, 1, 0, 0, 7, 1, 1, 0, 64'h0, 64'h0));
        s.push_back(st("iss7_full2", 1, 0, 0, 64'h0,  0, 1, 0, 0, 7, 1, 1, 0, 64'h0, 64'h0));
        s.push_back(st("iss7_rel",   1, 1, 7, 64'h70, 0, 1, 0, 0, 7, 1, 1, 0, 64'h0, 64'h0));
        s.push_back(st("iss7_retry", 1, 0, 0, 64'h0,  0, 1, 0, 0, 7, 1, 0, 0, 64'h0, 64'h0));
        for (int k = 1; k <= 3; k++) begin
            s.push_back(st($sformatf("rel7_%0d", k), 1, 1, 7, 64'h70 + 64'(k), 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0));
        end
        s.push_back(st("busy7",      1, 0, 0, 64'h0,  0, 1, 7, 0, 0, 0, 1, 1, 64'h73, 64'h0));
        s.push_back(st("rel7_last",  1, 1, 7, 64'h74, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0));
        s.push_back(st("free7",      1, 0, 0, 64'h0,  0, 1, 7, 0, 0, 0, 0, 1, 64'h74, 64'h0));
        foreach (s[i]) begin
            drive(s[i]);
            sb.push_back(to_exp(s[i]));
            @(negedge CLK);
            e = sb.pop_front();
            n_checks++;
            if (DE_STALL !== e.stall) begin
                n_fail++;
                $display("[TB] FAIL %s stall: got %b expected %b", e.name, DE_STALL, e.stall);
            end
            if (e.chk) begin
                n_checks += 2;
                if (DE_SR1_DATA !== e.d1) begin
                    n_fail++;
                    $display("[TB] FAIL %s sr1_data: got %h expected %h", e.name, DE_SR1_DATA, e.d1);
                end
                if (DE_SR2_DATA !== e.d2) begin
                    n_fail++;
                    $display("[TB] FAIL %s sr2_data: got %h expected %h", e.name, DE_SR2_DATA, e.d2);
                end
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_back_to_back();
        step_t s [$];
        exp_t  e;
        s.push_back(st("iss9",      1, 0, 0, 64'h0,  0, 1, 0, 0, 9, 1, 0, 0, 64'h0, 64'h0));
        s.push_back(st("iss9_rel9", 1, 1, 9, 64'h99, 0, 1, 0, 0, 9, 1, 0, 0, 64'h0, 64'h0));
        s.push_back(st("busy9",     1, 0, 0, 64'h0,  0, 1, 9, 0, 0, 0, 1, 1, 64'h99, 64'h0));
        s.push_back(st("rel9",      1, 1, 9, 64'h9A, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0));
        s.push_back(st("free9",     1, 0, 0, 64'h0,  0, 1, 0, 9, 0, 0, 0, 1, 64'h0, 64'h9A));
        foreach (s[i]) begin
            drive(s[i]);
            sb.push_back(to_exp(s[i]));
            @(negedge CLK);
            e = sb.pop_front();
            n_checks++;
            if (DE_STALL !== e.stall) begin
                n_fail++;
                $display("[TB] FAIL %s stall: got %b expected %b", e.name, DE_STALL, e.stall);
            end
            if (e.chk) begin
                n_checks += 2;
                if (DE_SR1_DATA !== e.d1) begin
                    n_fail++;
                    $display("[TB] FAIL %s sr1_data: got %h expected %h", e.name, DE_SR1_DATA, e.d1);
                end
                if (DE_SR2_DATA !== e.d2) begin
                    n_fail++;
                    $display("[TB] FAIL %s sr2_data: got %h expected %h", e.name, DE_SR2_DATA, e.d2);
                end
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_flush();
        step_t s [$];
        exp_t  e;
        s.push_back(st("iss4",    1, 0, 0, 64'h0,  0, 1, 0, 0, 4,  1, 0, 0, 64'h0, 64'h0));
        s.push_back(st("iss5",    1, 0, 0, 64'h0,  0, 1, 0, 0, 5,  1, 0, 0, 64'h0, 64'h0));
        s.push_back(st("iss6",    1, 0, 0, 64'h0,  0, 1, 0, 0, 6,  1, 0, 0, 64'h0, 64'h0));
        s.push_back(st("flush",   1, 1, 1, 64'h40, 1, 1, 4, 5, 10, 1, 0, 1, 64'h0, 64'h0));
        s.push_back(st("post_fl", 1, 0, 0, 64'h0,  0, 1, 5, 6, 4,  1, 0, 1, 64'h0, 64'h0));
        s.push_back(st("rd_x1",   1, 0, 0, 64'h0,  0, 1, 1, 10, 0, 0, 0, 1, 64'h40, 64'h0));
        s.push_back(st("busy4",   1, 0, 0, 64'h0,  0, 1, 4, 0, 0,  0, 1, 0, 64'h0, 64'h0));
        s.push_back(st("flush2",  1, 0, 0, 64'h0,  1, 0, 0, 0, 0,  0, 0, 0, 64'h0, 64'h0));
        s.push_back(st("free4",   1, 0, 0, 64'h0,  0, 1, 4, 0, 0,  0, 0, 1, 64'h0, 64'h0));
        foreach (s[i]) begin
            drive(s[i]);
            sb.push_back(to_exp(s[i]));
            @(negedge CLK);
            e = sb.pop_front();
            n_checks++;
            if (DE_STALL !== e.stall) begin
                n_fail++;
                $display("[TB] FAIL %s stall: got %b expected %b", e.name, DE_STALL, e.stall);
            end
            if (e.chk) begin
                n_checks += 2;
                if (DE_SR1_DATA !== e.d1) begin
                    n_fail++;
                    $display("[TB] FAIL %s sr1_data: got %h expected %h", e.name, DE_SR1_DATA, e.d1);
                end
                if (DE_SR2_DATA !== e.d2) begin
                    n_fail++;
                    $display("[TB] FAIL %s sr2_data: got %h expected %h", e.name, DE_SR2_DATA, e.d2);
                end
            end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_spurious_and_reset();
        step_t s [$];
        exp_t  e;
        s.push_back(st("spur8",     1, 1, 8,  64'h88, 0, 0, 0, 0,  0,  0, 0, 0, 64'h0, 64'h0));
        s.push_back(st("rd8",       1, 0, 0,  64'h0,  0, 1, 8, 0,  0,  0, 0, 1, 64'h88, 64'h0));
        s.push_back(st("iss8",      1, 0, 0,  64'h0,  0, 1, 0, 0,  8,  1, 0, 0, 64'h0, 64'h0));
        s.push_back(st("busy8",     1, 0, 0,  64'h0,  0, 1, 8, 0,  0,  0, 1, 1, 64'h88, 64'h0));
        s.push_back(st("iss11",     1, 0, 0,  64'h0,  0, 1, 0, 0,  11, 1, 0, 0, 64'h0, 64'h0));
        s.push_back(st("rst_mid",   0, 1, 13, 64'h55, 0, 1, 0, 0,  12, 1, 0, 0, 64'h0, 64'h0));
        s.push_back(st("post_rst",  1, 0, 0,  64'h0,  0, 1, 8, 11, 0,  0, 0, 1, 64'h0, 64'h0));
        s.push_back(st("post_rst2", 1, 0, 0,  64'h0,  0, 1, 1, 13, 0,  0, 0, 1, 64'h0, 64'h0));
        s.push_back(st("post_rst3", 1, 0, 0,  64'h0,  0, 1, 12, 0, 0,  0, 0, 1, 64'h0, 64'h0));
        foreach (s[i]) begin
            drive(s[i]);
            sb.push_back(to_exp(s[i]));
            @(negedge CLK);
            e = sb.pop_front();
            n_checks++;
            if (DE_STALL !== e.stall) begin
                n_fail++;
                $display("[TB] FAIL %s stall: got %b expected %b", e.name, DE_STALL, e.stall);
            end
            if (e.chk) begin
                n_checks += 2;
                if (DE_SR1_DATA !== e.d1) begin
                    n_fail++;
                    $display("[TB] FAIL %s sr1_data: got %h expected %h", e.name, DE_SR1_DATA, e.d1);
                end
                if (DE_SR2_DATA !== e.d2) begin
                    n_fail++;
                    $display("[TB] FAIL %s sr2_data: got %h expected %h", e.name, DE_SR2_DATA, e.d2);
                end
            end
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        RESET_N    = 1'b0;
        WB_REG_WEN = 1'b0;
        WB_DR      = '0;
        WB_DATA    = '0;
        WB_FLUSH   = 1'b0;
        DE_V       = 1'b0;
        DE_SR1     = '0;
        DE_SR2     = '0;
        DE_DR      = '0;
        DE_DR_WEN  = 1'b0;
        @(posedge CLK); #1;
        test_reset();
        test_raw_hazard();
        test_saturation();
        test_back_to_back();
        test_flush();
        test_spurious_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
